// File: rtl/ahblite_disp_regs_pkg.sv
// Shared definitions for the AHB-Lite display register bank: CTRL/STAT bit
// positions, error/ready FSM states and the byte-lane decoder.
package disp_regs_pkg;

  localparam int PEND_BIT = 0;
  localparam int IMM_BIT  = 1;
  localparam int FCNT_LSB = 16;
  localparam int FCNT_MSB = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } err_state_e;

  typedef struct packed {
    logic [3:0] strb;
    logic       ok;
  } lane_t;

  // Little-endian lane select; unaligned halfword/word and sizes above a word are illegal.
  function automatic lane_t lane_decode(input logic [2:0] size, input logic [1:0] lo);
    lane_t r;
    r.strb = 4'b0000;
    r.ok   = 1'b0;
    case (size)
      3'd0: begin
        r.strb = 4'b0001 << lo;
        r.ok   = 1'b1;
      end
      3'd1: begin
        r.strb = lo[1] ? 4'b1100 : 4'b0011;
        r.ok   = ~lo[0];
      end
      3'd2: begin
        r.strb = 4'b1111;
        r.ok   = (lo == 2'b00);
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ahblite_disp_regs_err_fsm.sv
// AHB-Lite ready/response sequencer: zero-wait legal data phases and the
// two-cycle ERROR response for rejected transfers.
module ahb_err_fsm
  import disp_regs_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic acc,
  input  logic legal,
  output logic hreadyout,
  output logic hresp,
  output logic dvld
);

  err_state_e state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      dvld      <= 1'b0;
    end else if (state == ST_ERR1) begin
      state     <= ST_ERR2;
      hreadyout <= 1'b1;
      hresp     <= 1'b1;
      dvld      <= 1'b0;
    end else if (acc && legal) begin
      state     <= ST_DATA;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      dvld      <= 1'b1;
    end else if (acc) begin
      state     <= ST_ERR1;
      hreadyout <= 1'b0;
      hresp     <= 1'b1;
      dvld      <= 1'b0;
    end else begin
      state     <= ST_IDLE;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      dvld      <= 1'b0;
    end
  end

endmodule

// File: rtl/ahblite_disp_regs.sv
// AHB-Lite display configuration registers: writes land in a shadow bank that is
// copied to CFG_DATA on a VSYNC rising edge when pending, or per-write in IMM mode.
module ahblite_disp_regs
  import disp_regs_pkg::*;
#(
  parameter int          NREG = 4,
  parameter logic [31:0] RST0 = 32'h0000_0001,
  parameter int          AW   = 8
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic [2:0]         HSIZE,
  input  logic [3:0]         HPROT,
  input  logic               HWRITE,
  input  logic [31:0]        HWDATA,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic [31:0]        HRDATA,
  output logic               HRESP,
  input  logic               VSYNC,
  output logic [NREG*32-1:0] CFG_DATA,
  output logic               COMMIT
);

  localparam int IW = AW - 2;
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [IW-1:0] idx_a;
  lane_t         lane_a;
  logic          acc;
  logic          legal_a;

  logic [IW-1:0] idx_p0;
  logic [3:0]    strb_p0;
  logic          wr_p0;
  logic          dvld;

  logic [31:0]   shadow [NREG];
  logic [31:0]   active [NREG];
  logic          pend;
  logic          imm;
  logic [15:0]   fcnt;
  logic          vs_q;
  logic          commit_q;

  logic          rise;
  logic          do_commit;
  logic          is_reg;
  logic          is_ctl;
  logic          wr_reg;
  logic          wr_ctl;
  logic [RW-1:0] ridx;
  logic [31:0]   wmask;
  logic [31:0]   ctrl_word;
  logic          unused;

  assign unused = ^{HPROT, HADDR[31:AW], HTRANS[0]};

  // Address phase: decode and qualify
  assign idx_a   = HADDR[AW-1:2];
  assign lane_a  = lane_decode(HSIZE, HADDR[1:0]);
  assign acc     = HSEL & HTRANS[1] & HREADY;
  assign legal_a = lane_a.ok & ({1'b0, idx_a} <= (IW+1)'(NREG));

  ahb_err_fsm u_fsm (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .acc       (acc),
    .legal     (legal_a),
    .hreadyout (HREADYOUT),
    .hresp     (HRESP),
    .dvld      (dvld)
  );

  // Data phase: registered index/strobes drive the register file
  assign ridx      = idx_p0[RW-1:0];
  assign is_reg    = ({1'b0, idx_p0} <  (IW+1)'(NREG));
  assign is_ctl    = ({1'b0, idx_p0} == (IW+1)'(NREG));
  assign wr_reg    = dvld & wr_p0 & is_reg;
  assign wr_ctl    = dvld & wr_p0 & is_ctl;
  assign wmask     = {{8{strb_p0[3]}}, {8{strb_p0[2]}}, {8{strb_p0[1]}}, {8{strb_p0[0]}}};
  assign rise      = VSYNC & ~vs_q;
  assign do_commit = rise & pend;

  always_comb begin
    ctrl_word                    = '0;
    ctrl_word[PEND_BIT]          = pend;
    ctrl_word[IMM_BIT]           = imm;
    ctrl_word[FCNT_MSB:FCNT_LSB] = fcnt;
  end

  assign HRDATA = (dvld & ~wr_p0) ? (is_reg ? shadow[ridx] : ctrl_word) : 32'd0;
  assign COMMIT = commit_q;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < NREG; i++) begin
        shadow[i] <= (i == 0) ? RST0 : 32'd0;
        active[i] <= (i == 0) ? RST0 : 32'd0;
      end
      idx_p0   <= '0;
      strb_p0  <= '0;
      wr_p0    <= 1'b0;
      pend     <= 1'b0;
      imm      <= 1'b0;
      fcnt     <= '0;
      vs_q     <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      vs_q     <= VSYNC;
      commit_q <= do_commit | (wr_reg & imm);
      if (acc) begin
        idx_p0  <= idx_a;
        strb_p0 <= lane_a.strb;
        wr_p0   <= HWRITE;
      end
      if (rise) begin
        fcnt <= fcnt + 16'd1;
      end
      if (do_commit) begin
        pend <= 1'b0;
      end
      // A commit sees the pre-write shadow; an IMM write overrides its own lanes.
      for (int i = 0; i < NREG; i++) begin
        if (do_commit) begin
          active[i] <= shadow[i];
        end
        if (wr_reg && ridx == RW'(i)) begin
          shadow[i] <= (shadow[i] & ~wmask) | (HWDATA & wmask);
          if (imm) begin
            active[i] <= ((do_commit ? shadow[i] : active[i]) & ~wmask) | (HWDATA & wmask);
          end
        end
      end
      if (wr_ctl && strb_p0[0]) begin
        imm <= HWDATA[IMM_BIT];
        if (HWDATA[PEND_BIT]) begin
          pend <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_cfg
    assign CFG_DATA[32*g +: 32] = active[g];
  end

endmodule
